// File: rtl/test1_pkg.sv
// test1_pkg: grid geometry, object codes and scan FSM states shared by the
// snake image scan controller and its frame buffer.
package test1_pkg;
    localparam int GRID_W = 16;
    localparam int GRID_H = 12;
    localparam int XW     = 4;
    localparam int YW     = 4;
    localparam int CELLS  = GRID_W * GRID_H;

    typedef enum logic [2:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_BODY   = 3'd1,
        OBJ_HEAD   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_e;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_CMD, FRAME_END} state_e;
endpackage

// File: rtl/test1_frame_buffer.sv
// test1_frame_buffer: last drawn object code per grid cell, one read and one
// write port at the same (x,y), synchronous clear, async reset to EMPTY.
module test1_frame_buffer
    import test1_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  obj_e          wdata_i,
    output obj_e          rdata_o
);
    obj_e       mem_q [CELLS];
    logic [7:0] addr;

    // Row-major address: y*16 + x, max 191 for a 16x12 grid
    assign addr    = {y_i, x_i};
    assign rdata_o = mem_q[addr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < CELLS; i++) mem_q[i] <= OBJ_EMPTY;
        end else if (clr_i) begin
            for (int i = 0; i < CELLS; i++) mem_q[i] <= OBJ_EMPTY;
        end else if (we_i) begin
            mem_q[addr] <= wdata_i;
        end
    end
endmodule

// File: rtl/test_1.sv
// test_1: snake image scan controller, walks the grid and flags cells to redraw.
// Define TEST1_FRAME_BUFFER_EN to send only changed cells; otherwise every cell is sent.
module test_1
    import test1_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clk2,
    input  logic       snakeBody,
    input  logic       snakeHead,
    input  logic       apple,
    input  logic       border,
    input  logic       mode_pb,
    input  logic       GameOver,
    input  logic       cmd_done,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [2:0] obj_code,
    output logic       diff,
    output logic       enable_loop,
    output logic       init_cycle,
    output logic       en_update,
    output logic       sync_reset
);
    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    obj_e          obj_q, obj_d, code;
    logic          init_q, init_d, diff_q, loop_q, upd_q, srst_q, mode_q, go_q;
    logic          restart, last, send, adv, unused_clk2;

    assign unused_clk2 = clk2;
    assign restart = (mode_pb & ~mode_q) | (GameOver & ~go_q);
    assign last    = x_q == XW'(GRID_W - 1) && y_q == YW'(GRID_H - 1);
    assign code    = snakeHead ? OBJ_HEAD : snakeBody ? OBJ_BODY :
                     apple ? OBJ_APPLE : border ? OBJ_BORDER : OBJ_EMPTY;

`ifdef TEST1_FRAME_BUFFER_EN
    obj_e buf_rd;

    test1_frame_buffer u_fb (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (restart),
        .we_i    (state_q == SCAN && send),
        .x_i     (x_q),
        .y_i     (y_q),
        .wdata_i (code),
        .rdata_o (buf_rd)
    );

    assign send = init_q || code != buf_rd;
`else
    assign send = 1'b1;
`endif

    assign adv = !restart && ((state_q == SCAN && !send) || (state_q == WAIT_CMD && cmd_done));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            obj_q   <= OBJ_EMPTY;
            init_q  <= 1'b1;
            diff_q  <= 1'b0;
            loop_q  <= 1'b0;
            upd_q   <= 1'b0;
            srst_q  <= 1'b0;
            mode_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            obj_q   <= obj_d;
            init_q  <= init_d;
            diff_q  <= state_d == WAIT_CMD;
            loop_q  <= state_d != IDLE;
            upd_q   <= state_d == FRAME_END;
            srst_q  <= restart;
            mode_q  <= mode_pb;
            go_q    <= GameOver;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) state_d = IDLE;
        else case (state_q)
            IDLE:     state_d = cmd_done ? SCAN : IDLE;
            SCAN:     state_d = send ? WAIT_CMD : last ? FRAME_END : SCAN;
            WAIT_CMD: state_d = !cmd_done ? WAIT_CMD : last ? FRAME_END : SCAN;
            default:  state_d = SCAN;
        endcase
    end

    // x wraps naturally at 15; the last cell also wraps y back to row 0
    always_comb begin
        x_d    = restart ? '0 : adv ? x_q + 4'd1 : x_q;
        y_d    = restart || (adv && last) ? '0 :
                 adv && x_q == XW'(GRID_W - 1) ? y_q + 4'd1 : y_q;
        obj_d  = !restart && state_q == SCAN && send ? code : obj_q;
        init_d = restart ? 1'b1 : state_d == FRAME_END ? 1'b0 : init_q;
    end

    assign x           = x_q;
    assign y           = y_q;
    assign obj_code    = obj_q;
    assign diff        = diff_q;
    assign enable_loop = loop_q;
    assign init_cycle  = init_q;
    assign en_update   = upd_q;
    assign sync_reset  = srst_q;
endmodule

// File: tb/tb_test_1.sv
// tb_test_1: directed self-checking bench for the test_1 scan controller;
// expectations adapt to whether TEST1_FRAME_BUFFER_EN is defined.
module tb_test_1;
`ifdef TEST1_FRAME_BUFFER_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    logic clk = 1'b0, nrst = 1'b0, mode_pb = 1'b0, GameOver = 1'b0, cmd_done = 1'b0;
    logic snakeBody, snakeHead, apple, border;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic diff, enable_loop, init_cycle, en_update, sync_reset;
    logic [7:0] xy;
    logic [10:0] rec [256];
    int scene = 0, cyc = 0, checks = 0, errors = 0, nrec = 0;
    bit timeout;

    test_1 dut (
        .clk(clk), .nrst(nrst), .clk2(clk), .snakeBody(snakeBody), .snakeHead(snakeHead),
        .apple(apple), .border(border), .mode_pb(mode_pb), .GameOver(GameOver),
        .cmd_done(cmd_done), .x(x), .y(y), .obj_code(obj_code), .diff(diff),
        .enable_loop(enable_loop), .init_cycle(init_cycle), .en_update(en_update),
        .sync_reset(sync_reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Game-logic stand-in: flags follow the presented (x,y) for the active scene
    assign xy        = {x, y};
    assign border    = x == 4'd0 || x == 4'd15 || y == 4'd0 || y == 4'd11;
    assign snakeHead = scene == 0 ? xy == 8'h44 : scene == 1 ? xy == 8'h54 : xy == 8'h76;
    assign snakeBody = scene == 2 && (xy == 8'h76 || xy == 8'hA8);
    assign apple     = scene == 2 && (xy == 8'h92 || xy == 8'h05 || xy == 8'h76);

    function automatic logic [2:0] model(int s, int i);
        logic [7:0] c;
        logic h, b, a, w;
        c = {4'(i % 16), 4'(i / 16)};
        h = s == 0 ? c == 8'h44 : s == 1 ? c == 8'h54 : c == 8'h76;
        b = s == 2 && (c == 8'h76 || c == 8'hA8);
        a = s == 2 && (c == 8'h92 || c == 8'h05 || c == 8'h76);
        w = c[7:4] == 4'd0 || c[7:4] == 4'd15 || c[3:0] == 4'd0 || c[3:0] == 4'd11;
        return h ? 3'd2 : b ? 3'd1 : a ? 3'd3 : w ? 3'd4 : 3'd0;
    endfunction

    function automatic int find(int fx, int fy);
        for (int k = 0; k < nrec && k < 256; k++)
            if (rec[k][10:7] == 4'(fx) && rec[k][6:3] == 4'(fy)) return int'(rec[k][2:0]);
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd;
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
    endtask

    // Acknowledge every diff immediately and log it until the frame-end pulse
    task automatic collect_frame;
        int n;
        n = 0;
        nrec = 0;
        while (en_update !== 1'b1 && n < 2000) begin
            if (diff === 1'b1) begin
                if (nrec < 256) rec[nrec] = {x, y, obj_code};
                nrec++;
                pulse_cmd;
            end else tick;
            n++;
        end
        timeout = en_update !== 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        nrst = 1'b1;
        repeat (5) tick;
        checks++; if (x !== 4'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x); end
        checks++; if (y !== 4'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (init_cycle !== 1'b1) begin errors++; $display("FAIL reset_init: got %b expected 1", init_cycle); end
        checks++; if (enable_loop !== 1'b0) begin errors++; $display("FAIL reset_loop: got %b expected 0", enable_loop); end
        checks++; if (diff !== 1'b0) begin errors++; $display("FAIL reset_diff: got %b expected 0", diff); end
        checks++; if ({en_update, sync_reset, obj_code} !== 5'd0) begin errors++; $display("FAIL reset_misc: got %b expected 00000", {en_update, sync_reset, obj_code}); end
    endtask

    task automatic test_init_frame;
        logic [10:0] e;
        scene = 0;
        pulse_cmd;
        checks++; if (enable_loop !== 1'b1) begin errors++; $display("FAIL init_loop: got %b expected 1", enable_loop); end
        tick;
        checks++; if ({diff, x, y, obj_code} !== {1'b1, 4'd0, 4'd0, 3'd4}) begin errors++; $display("FAIL init_first: got %b expected 1_0000_0000_100", {diff, x, y, obj_code}); end
        collect_frame;
        checks++; if (timeout || nrec !== 192) begin errors++; $display("FAIL init_count: got %0d diffs timeout=%0d expected 192", nrec, timeout); end
        for (int i = 0; i < 192; i++) begin
            e = {4'(i % 16), 4'(i / 16), model(0, i)};
            checks++; if (rec[i] !== e) begin errors++; $display("FAIL init_cell%0d: got %h expected %h", i, rec[i], e); end
        end
        checks++; if (init_cycle !== 1'b0 || diff !== 1'b0) begin errors++; $display("FAIL init_end: got init=%b diff=%b expected 0 0", init_cycle, diff); end
    endtask

    task automatic test_same_frame;
        int s0;
        s0 = cyc;
        tick;
        checks++; if (en_update !== 1'b0) begin errors++; $display("FAIL upd_width: got %b expected 0", en_update); end
        collect_frame;
        checks++; if (timeout || cyc - s0 !== (FB ? 193 : 385)) begin errors++; $display("FAIL same_period: got %0d expected %0d", cyc - s0, FB ? 193 : 385); end
        checks++; if (nrec !== (FB ? 0 : 192)) begin errors++; $display("FAIL same_diffs: got %0d expected %0d", nrec, FB ? 0 : 192); end
        checks++; if (init_cycle !== 1'b0) begin errors++; $display("FAIL same_init: got %b expected 0", init_cycle); end
    endtask

    task automatic test_head_move;
        scene = 1;
        tick;
        collect_frame;
        checks++; if (timeout || nrec !== (FB ? 2 : 192)) begin errors++; $display("FAIL move_count: got %0d expected %0d", nrec, FB ? 2 : 192); end
        checks++; if (find(4, 4) !== 0) begin errors++; $display("FAIL move_old: got %0d expected 0", find(4, 4)); end
        checks++; if (find(5, 4) !== 2) begin errors++; $display("FAIL move_new: got %0d expected 2", find(5, 4)); end
    endtask

    task automatic test_priority;
        scene = 2;
        tick;
        collect_frame;
        checks++; if (timeout || nrec !== (FB ? 5 : 192)) begin errors++; $display("FAIL prio_count: got %0d expected %0d", nrec, FB ? 5 : 192); end
        checks++; if (find(7, 6) !== 2) begin errors++; $display("FAIL prio_head_apple_body: got %0d expected 2", find(7, 6)); end
        checks++; if (find(9, 2) !== 3) begin errors++; $display("FAIL prio_apple: got %0d expected 3", find(9, 2)); end
        checks++; if (find(10, 8) !== 1) begin errors++; $display("FAIL prio_body: got %0d expected 1", find(10, 8)); end
        checks++; if (find(0, 5) !== 3) begin errors++; $display("FAIL prio_apple_border: got %0d expected 3", find(0, 5)); end
        checks++; if (find(5, 4) !== 0) begin errors++; $display("FAIL prio_cleared: got %0d expected 0", find(5, 4)); end
    endtask

    task automatic test_gameover;
        int n;
        n = 0;
        scene = 0;
        tick;
        while (diff !== 1'b1 && n < 400) begin tick; n++; end
        checks++; if (diff !== 1'b1) begin errors++; $display("FAIL go_wait: got %b expected 1", diff); end
        GameOver = 1'b1;
        tick;
        checks++; if (sync_reset !== 1'b1) begin errors++; $display("FAIL go_sync: got %b expected 1", sync_reset); end
        checks++; if ({x, y} !== 8'd0) begin errors++; $display("FAIL go_xy: got %h expected 00", {x, y}); end
        checks++; if ({diff, init_cycle, enable_loop} !== 3'b010) begin errors++; $display("FAIL go_flags: got %b expected 010", {diff, init_cycle, enable_loop}); end
        tick;
        checks++; if (sync_reset !== 1'b0) begin errors++; $display("FAIL go_pulse: got %b expected 0", sync_reset); end
        repeat (3) tick;
        checks++; if ({enable_loop, diff, x, y} !== 10'd0) begin errors++; $display("FAIL go_idle: got %b expected 0", {enable_loop, diff, x, y}); end
    endtask

    task automatic test_mode;
        pulse_cmd;
        tick;
        checks++; if ({diff, enable_loop, obj_code} !== 5'b11100) begin errors++; $display("FAIL mode_redraw: got %b expected 11100", {diff, enable_loop, obj_code}); end
        mode_pb = 1'b1;
        tick;
        checks++; if ({sync_reset, enable_loop, diff, init_cycle} !== 4'b1001) begin errors++; $display("FAIL mode_restart: got %b expected 1001", {sync_reset, enable_loop, diff, init_cycle}); end
        mode_pb = 1'b0;
        GameOver = 1'b0;
        tick;
        checks++; if (sync_reset !== 1'b0) begin errors++; $display("FAIL mode_fall: got %b expected 0", sync_reset); end
    endtask

    initial begin
        test_reset;
        test_init_frame;
        test_same_frame;
        test_head_move;
        test_priority;
        test_gameover;
        test_mode;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
